// File: rtl/jr_hazard_ctrl_pkg.sv
// Shared types for the jr hazard controller: FSM state encoding and
// jump-register forward-select codes.
package jr_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        FIRE = 2'b10
    } jrState_t;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_ALUM = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

endpackage

// File: rtl/jr_hazard_ctrl_if.sv
// Pipeline-side signals of the jr hazard controller: D/E/M/W writer info in,
// stall/flush/forward/redirect controls out.
interface jr_hazard_ctrl_if;

    logic       IfjrD;
    logic [4:0] RsD;
    logic       RegWriteE;
    logic       MemtoRegE;
    logic [4:0] RdE;
    logic       RegWriteM;
    logic       MemtoRegM;
    logic [4:0] RdM;
    logic       RegWriteW;
    logic [4:0] RdW;

    logic       StallF;
    logic       StallD;
    logic       FlushE;
    logic [1:0] ForwardJrD;
    logic       JumpReg;
    logic       TimeoutErr;

    modport master (
        output IfjrD, RsD, RegWriteE, MemtoRegE, RdE,
               RegWriteM, MemtoRegM, RdM, RegWriteW, RdW,
        input  StallF, StallD, FlushE, ForwardJrD, JumpReg, TimeoutErr
    );

    modport slave (
        input  IfjrD, RsD, RegWriteE, MemtoRegE, RdE,
               RegWriteM, MemtoRegM, RdM, RegWriteW, RdW,
        output StallF, StallD, FlushE, ForwardJrD, JumpReg, TimeoutErr
    );

endinterface

// File: rtl/jr_fwd_sel.sv
// Combinational hazard detect and forward-source select for the jr target,
// with register $0 never treated as a dependency.
module jr_fwd_sel
    import jr_hazard_ctrl_pkg::*;
(
    input  logic       IfjrD,
    input  logic [4:0] RsD,
    input  logic       RegWriteE,
    input  logic [4:0] RdE,
    input  logic       RegWriteM,
    input  logic       MemtoRegM,
    input  logic [4:0] RdM,
    input  logic       RegWriteW,
    input  logic [4:0] RdW,
    output logic       Hazard,
    output logic [1:0] ForwardJrD
);

    logic rsLive;

    assign rsLive = IfjrD && (RsD != 5'd0);

    // E results are never ready in D; M load data only arrives in W.
    assign Hazard = rsLive &&
                    ((RegWriteE && (RdE == RsD)) ||
                     (RegWriteM && MemtoRegM && (RdM == RsD)));

    always_comb begin
        ForwardJrD = FWD_RF;
        if (rsLive) begin
            if (RegWriteM && !MemtoRegM && (RdM == RsD)) begin
                ForwardJrD = FWD_ALUM;
            end else if (RegWriteW && (RdW == RsD)) begin
                ForwardJrD = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/jr_hazard_ctrl.sv
// Decode-stage jr sequencer: stalls on RAW hazards, then redirects with the
// forwarded target. JR_STATS_EN adds jr and stall statistics counters.
//
// state | meaning
// IDLE  | no jr pending; a clean jr fires at once
// WAIT  | jr stalled in D until its rs producer is forwardable
// FIRE  | redirect issued last cycle; behaves like IDLE for a back-to-back jr
module jr_hazard_ctrl
    import jr_hazard_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    jr_hazard_ctrl_if.slave     bus
`ifdef JR_STATS_EN
    ,
    output logic [CNT_W-1:0]    JrCount,
    output logic [CNT_W-1:0]    StallCount
`endif
);

    localparam logic [3:0] STALL_TC = 4'(MAX_STALL);

    jrState_t   state;
    jrState_t   stateNext;
    logic [3:0] stallCnt;
    logic [3:0] stallCntNext;
    logic       timeoutErr;
    logic       hazard;
    logic [1:0] fwdSel;
    logic       stall;
    logic       jumpReg;

    jr_fwd_sel uFwdSel (
        .IfjrD      (bus.IfjrD),
        .RsD        (bus.RsD),
        .RegWriteE  (bus.RegWriteE),
        .RdE        (bus.RdE),
        .RegWriteM  (bus.RegWriteM),
        .MemtoRegM  (bus.MemtoRegM),
        .RdM        (bus.RdM),
        .RegWriteW  (bus.RegWriteW),
        .RdW        (bus.RdW),
        .Hazard     (hazard),
        .ForwardJrD (fwdSel)
    );

    always_comb begin
        stateNext    = state;
        stallCntNext = stallCnt;
        stall        = 1'b0;
        jumpReg      = 1'b0;
        case (state)
            WAIT: begin
                if (!bus.IfjrD) begin
                    stateNext    = IDLE;
                    stallCntNext = 4'd0;
                end else if (hazard) begin
                    stall = 1'b1;
                    if (stallCnt != 4'd15) stallCntNext = stallCnt + 4'd1;
                end else begin
                    jumpReg      = 1'b1;
                    stateNext    = FIRE;
                    stallCntNext = 4'd0;
                end
            end
            default: begin
                if (bus.IfjrD && hazard) begin
                    stall     = 1'b1;
                    stateNext = WAIT;
                end else if (bus.IfjrD) begin
                    jumpReg   = 1'b1;
                    stateNext = FIRE;
                end else begin
                    stateNext = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            stallCnt   <= 4'd0;
            timeoutErr <= 1'b0;
        end else begin
            state    <= stateNext;
            stallCnt <= stallCntNext;
            if (stallCntNext == STALL_TC) timeoutErr <= 1'b1;
        end
    end

    assign bus.StallF     = stall;
    assign bus.StallD     = stall;
    assign bus.FlushE     = stall;
    assign bus.JumpReg    = jumpReg;
    assign bus.ForwardJrD = fwdSel;
    assign bus.TimeoutErr = timeoutErr;

`ifdef JR_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            JrCount    <= '0;
            StallCount <= '0;
        end else begin
            if (jumpReg) JrCount    <= JrCount + CNT_W'(1);
            if (stall)   StallCount <= StallCount + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_jr_hazard_ctrl.sv
// Scoreboard bench for jr_hazard_ctrl: directed per-cycle vectors push the
// expected outputs, a negedge monitor pops and compares.
module tb_jr_hazard_ctrl;

    logic clk;
    logic reset;

    jr_hazard_ctrl_if bus ();

`ifdef JR_STATS_EN
    logic [15:0] JrCount;
    logic [15:0] StallCount;
`endif

    jr_hazard_ctrl #(.MAX_STALL(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef JR_STATS_EN
        ,
        .JrCount    (JrCount),
        .StallCount (StallCount)
`endif
    );

    // {StallF, StallD, FlushE, ForwardJrD[1:0], JumpReg, TimeoutErr}
    localparam logic [6:0] ZERO     = 7'b0000000;
    localparam logic [6:0] STL      = 7'b1110000;
    localparam logic [6:0] JMP_RF   = 7'b0000010;
    localparam logic [6:0] JMP_ALUM = 7'b0000110;
    localparam logic [6:0] JMP_WB   = 7'b0001010;
    localparam logic [6:0] TO       = 7'b0000001;

    typedef struct {
        logic [6:0] vec;
        bit         statsChk;
        int         jr;
        int         stl;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string name, input bit rst, input bit ifjr, input logic [4:0] rs,
                        input bit rwE, input bit m2rE, input logic [4:0] rdE,
                        input bit rwM, input bit m2rM, input logic [4:0] rdM,
                        input bit rwW, input logic [4:0] rdW, input logic [6:0] vec,
                        input bit sc = 1'b0, input int jr = 0, input int stl = 0);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.IfjrD     = ifjr;
        bus.RsD       = rs;
        bus.RegWriteE = rwE;
        bus.MemtoRegE = m2rE;
        bus.RdE       = rdE;
        bus.RegWriteM = rwM;
        bus.MemtoRegM = m2rM;
        bus.RdM       = rdM;
        bus.RegWriteW = rwW;
        bus.RdW       = rdW;
        e.vec      = vec;
        e.statsChk = sc;
        e.jr       = jr;
        e.stl      = stl;
        e.name     = name;
        q.push_back(e);
    endtask

    task automatic idle(input string name, input logic [6:0] vec,
                        input bit sc = 1'b0, input int jr = 0, input int stl = 0);
        step(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, vec, sc, jr, stl);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {bus.StallF, bus.StallD, bus.FlushE, bus.ForwardJrD, bus.JumpReg, bus.TimeoutErr};
                checks++;
                if (act !== e.vec) begin
                    errors++;
                    $display("FAIL %s: outputs got %b expected %b", e.name, act, e.vec);
                end
`ifdef JR_STATS_EN
                if (e.statsChk) begin
                    checks++;
                    if (JrCount !== 16'(e.jr) || StallCount !== 16'(e.stl)) begin
                        errors++;
                        $display("FAIL %s_stats: JrCount=%0d StallCount=%0d expected %0d/%0d",
                                 e.name, JrCount, StallCount, e.jr, e.stl);
                    end
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1'b0;
        bus.IfjrD = 0; bus.RsD = 0; bus.RegWriteE = 0; bus.MemtoRegE = 0; bus.RdE = 0;
        bus.RegWriteM = 0; bus.MemtoRegM = 0; bus.RdM = 0; bus.RegWriteW = 0; bus.RdW = 0;

        //    name            rst jr rs  rwE m2rE rdE rwM m2rM rdM rwW rdW expected
        step("rst0",          0,  0, 0,  0,  0,   0,  0,  0,   0,  0,  0,  ZERO);
        step("rst1",          0,  0, 0,  0,  0,   0,  0,  0,   0,  0,  0,  ZERO, 1, 0, 0);
        idle("idle",          ZERO);
        step("alu_stall",     1,  1, 5,  1,  0,   5,  0,  0,   0,  0,  0,  STL);
        step("alu_fire",      1,  1, 5,  0,  0,   0,  1,  0,   5,  0,  0,  JMP_ALUM);
        idle("alu_after",     ZERO);
        step("ld_stall0",     1,  1, 8,  1,  1,   8,  0,  0,   0,  0,  0,  STL);
        step("ld_stall1",     1,  1, 8,  0,  0,   0,  1,  1,   8,  0,  0,  STL);
        step("ld_fire",       1,  1, 8,  0,  0,   0,  0,  0,   0,  1,  8,  JMP_WB);
        idle("ld_after",      ZERO);
        step("prio_m_over_w", 1,  1, 9,  0,  0,   0,  1,  0,   9,  1,  9,  JMP_ALUM);
        step("r0_b2b",        1,  1, 0,  1,  0,   0,  1,  0,   9,  1,  9,  JMP_RF);
        step("r0_all_zero",   1,  1, 0,  1,  1,   0,  1,  1,   0,  1,  0,  JMP_RF);
        idle("r0_after",      ZERO);
        step("nojr_gate",     1,  0, 9,  0,  0,   0,  1,  0,   9,  1,  9,  ZERO);
        step("flush_stall",   1,  1, 3,  1,  0,   3,  0,  0,   0,  0,  0,  STL);
        step("flush_drop",    1,  0, 3,  1,  0,   3,  0,  0,   0,  0,  0,  ZERO);
        step("w_fwd",         1,  1, 7,  0,  0,   0,  0,  0,   0,  1,  7,  JMP_WB);
        idle("w_after",       ZERO);
        for (int i = 0; i < 5; i++)
            step($sformatf("to_stall%0d", i), 1, 1, 4, 1, 0, 4, 0, 0, 0, 0, 0, STL);
        step("to_fire",       1,  1, 4,  0,  0,   0,  0,  0,   0,  0,  0,  JMP_RF | TO);
        idle("to_sticky",     TO);
        step("rw_stall0",     1,  1, 6,  1,  1,   6,  0,  0,   0,  0,  0,  STL | TO);
        step("rw_stall1_rst", 0,  1, 6,  0,  0,   0,  1,  1,   6,  0,  0,  STL | TO);
        idle("rw_after",      ZERO, 1, 0, 0);
        step("st_ld0",        1,  1, 2,  1,  1,   2,  0,  0,   0,  0,  0,  STL);
        step("st_ld1",        1,  1, 2,  0,  0,   0,  1,  1,   2,  0,  0,  STL);
        step("st_fire",       1,  1, 2,  0,  0,   0,  0,  0,   0,  1,  2,  JMP_WB);
        idle("st_gap",        ZERO);
        step("st_jr2",        1,  1, 11, 0,  0,   0,  0,  0,   0,  0,  0,  JMP_RF);
        step("st_jr3",        1,  1, 12, 0,  0,   0,  0,  0,   0,  0,  0,  JMP_RF);
        idle("st_end",        ZERO, 1, 3, 2);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
